// File: rtl/dll_pkg.sv
// Shared definitions for the DLL delay-code controller: FSM states, default
// code width and a counter-width helper.
package dll_pkg;

    localparam int DLL_CODE_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAR   = 2'd1,
        TRACK = 2'd2
    } dll_state_t;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dll_lock_det.sv
// Lock detector: counts direction reversals and same-direction runs of the
// tracking loop and maintains the registered lock flag.
module dll_lock_det
    import dll_pkg::*;
#(
    parameter int LOCK_TOGGLES = 4,
    parameter int UNLOCK_RUN   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic step,
    input  logic dir,
    output logic locked
);

    localparam int REV_W = cnt_w(LOCK_TOGGLES);
    localparam int RUN_W = cnt_w(UNLOCK_RUN);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(LOCK_TOGGLES);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(UNLOCK_RUN);

    logic             have_prev;
    logic             prev_dir;
    logic [REV_W-1:0] rev_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [REV_W-1:0] rev_next;
    logic [RUN_W-1:0] run_next;
    logic             reversal;
    logic             same_dir;

    // The first step after a clear has no predecessor, so it is neither a
    // reversal nor a continuation; both counters restart from zero.
    always_comb begin
        reversal = have_prev && (dir != prev_dir);
        same_dir = have_prev && (dir == prev_dir);
        rev_next = '0;
        run_next = '0;
        if (reversal) begin
            rev_next = (rev_cnt == REV_MAX) ? rev_cnt : rev_cnt + 1'b1;
        end
        if (same_dir) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev <= 1'b0;
            prev_dir  <= 1'b0;
            rev_cnt   <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
        end else if (clear) begin
            have_prev <= 1'b0;
            prev_dir  <= 1'b0;
            rev_cnt   <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
        end else if (step) begin
            have_prev <= 1'b1;
            prev_dir  <= dir;
            rev_cnt   <= rev_next;
            run_cnt   <= run_next;
            if (rev_next == REV_MAX) begin
                locked <= 1'b1;
            end else if (run_next == RUN_MAX) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dll_code_ctrl.sv
// DLL delay-code controller: binary search (SAR) to acquire the code, then
// +/-1 tracking with lock detection.
module dll_code_ctrl
    import dll_pkg::*;
#(
    parameter int CODE_W       = DLL_CODE_W,
    parameter int SETTLE_CYC   = 4,
    parameter int LOCK_TOGGLES = 4,
    parameter int UNLOCK_RUN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              pd_up,
    output logic [CODE_W-1:0] Q,
    output logic              busy,
    output logic              locked
);

    localparam int CNT_W = 4;
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CODE_W-1:0] CODE_MSB = CODE_W'(1) << (CODE_W - 1);

    dll_state_t        state;
    dll_state_t        state_next;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] trial_mask;
    logic [CODE_W-1:0] sar_code;
    logic [CODE_W-1:0] track_code;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              start_ok;
    logic              sample;
    logic              sar_done;
    logic              track_step;
    logic              lock_clear;

    assign start_ok   = en && start && (state != SAR);
    assign sample     = (cyc_cnt == CNT_LAST);
    assign sar_done   = (state == SAR) && sample && (bit_idx == '0);
    assign track_step = en && !start_ok && (state == TRACK) && sample;
    assign lock_clear = !en || start_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else if (start_ok) begin
            state_next = SAR;
        end else if (sar_done) begin
            state_next = TRACK;
        end
    end

    always_comb begin
        busy = (state == SAR);
    end

    // SAR resolves the current trial bit from pd_up and arms the next lower
    // one in the same update; tracking saturates at both ends of the range.
    always_comb begin
        trial_mask = CODE_W'(1) << bit_idx;
        sar_code   = pd_up ? code : (code & ~trial_mask);
        if (bit_idx != '0) begin
            sar_code = sar_code | (trial_mask >> 1);
        end
        if (pd_up) begin
            track_code = (code == CODE_MAX) ? code : code + 1'b1;
        end else begin
            track_code = (code == '0) ? code : code - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code    <= '0;
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else if (!en) begin
            cyc_cnt <= '0;
        end else if (start_ok) begin
            code    <= CODE_MSB;
            cyc_cnt <= '0;
            bit_idx <= IDX_TOP;
        end else if (state == SAR) begin
            if (sample) begin
                code    <= sar_code;
                cyc_cnt <= '0;
                if (bit_idx != '0) begin
                    bit_idx <= bit_idx - 1'b1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end else if (state == TRACK) begin
            if (sample) begin
                code    <= track_code;
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign Q = code;

    dll_lock_det #(
        .LOCK_TOGGLES (LOCK_TOGGLES),
        .UNLOCK_RUN   (UNLOCK_RUN)
    ) u_lock_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (lock_clear),
        .step   (track_step),
        .dir    (pd_up),
        .locked (locked)
    );

endmodule

// File: tb/tb_dll_code_ctrl.sv
// Directed bench for dll_code_ctrl with a closed-loop phase-detector model
// and a scoreboard of expected Q/busy/locked values.
module tb_dll_code_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       start;
    logic       pd_up;
    logic [9:0] q_out;
    logic       busy;
    logic       locked;

    typedef struct {
        string      tag;
        logic [9:0] q;
        logic       busy;
        logic       locked;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   pd_mode;
    int   target;

    dll_code_ctrl #(
        .CODE_W       (10),
        .SETTLE_CYC   (4),
        .LOCK_TOGGLES (4),
        .UNLOCK_RUN   (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .start  (start),
        .pd_up  (pd_up),
        .Q      (q_out),
        .busy   (busy),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected summary before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Phase detector: mode 0 compares against target, 1/2 are stuck at 1/0.
    task automatic drive_pd();
        case (pd_mode)
            0:       pd_up = (int'(q_out) < target);
            1:       pd_up = 1'b1;
            default: pd_up = 1'b0;
        endcase
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
        cyc++;
        drive_pd();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) step_clk();
    endtask

    task automatic start_sar();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic expect_out(input string tag, input int q, input bit b, input bit l);
        exp_t e;
        e.tag    = tag;
        e.q      = 10'(q);
        e.busy   = b;
        e.locked = l;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            assert ((q_out === e.q) && (busy === e.busy) && (locked === e.locked))
            else begin
                miscompares++;
                $error("[TB] FAIL %s: observed Q=%0d busy=%b locked=%b, expected Q=%0d busy=%b locked=%b",
                       e.tag, q_out, busy, locked, e.q, e.busy, e.locked);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        pd_mode     = 0;
        target      = 600;
        rst_n       = 1'b0;
        en          = 1'b0;
        start       = 1'b0;
        pd_up       = 1'b0;

        expect_out("reset_state", 0, 0, 0);
        #1;
        check_output();
        step_n(3);
        rst_n = 1'b1;
        en    = 1'b1;
        expect_out("idle_en_only", 0, 0, 0);
        step_n(6);
        check_output();

        // Acquire at target 600, track, lock, then unlock and relock at 700.
        expect_out("sar_start", 512, 1, 0);
        start_sar();
        check_output();
        expect_out("sar_bit0_pending", 599, 1, 0);
        advance_to(39);
        check_output();
        expect_out("sar_done_599", 599, 0, 0);
        advance_to(40);
        check_output();
        expect_out("track_step1", 600, 0, 0);
        advance_to(44);
        check_output();
        expect_out("track_rev3", 599, 0, 0);
        advance_to(56);
        check_output();
        expect_out("lock_rev4", 600, 0, 1);
        advance_to(60);
        check_output();

        target = 700;
        drive_pd();
        expect_out("run7_still_locked", 607, 0, 1);
        advance_to(88);
        check_output();
        expect_out("run8_unlock", 608, 0, 0);
        advance_to(92);
        check_output();
        expect_out("relock_rev3", 699, 0, 0);
        advance_to(472);
        check_output();
        expect_out("relock_rev4", 700, 0, 1);
        advance_to(476);
        check_output();

        // Disable in TRACK: idle, unlocked, code frozen even with PD asking up.
        en = 1'b0;
        expect_out("en_off", 700, 0, 0);
        step_clk();
        check_output();
        target = 900;
        drive_pd();
        expect_out("idle_frozen", 700, 0, 0);
        step_n(12);
        check_output();
        en = 1'b1;
        expect_out("en_on_no_leave", 700, 0, 0);
        step_n(12);
        check_output();

        // PD stuck high, with an ignored start pulse in the middle of SAR.
        pd_mode = 1;
        drive_pd();
        expect_out("sar_start_hi", 512, 1, 0);
        start_sar();
        check_output();
        advance_to(20);
        start = 1'b1;
        expect_out("start_ignored", 1008, 1, 0);
        step_clk();
        start = 1'b0;
        check_output();
        expect_out("hi_bit0_pending", 1023, 1, 0);
        advance_to(39);
        check_output();
        expect_out("hi_done", 1023, 0, 0);
        advance_to(40);
        check_output();
        expect_out("sat_high", 1023, 0, 0);
        advance_to(88);
        check_output();

        // PD stuck low, restarted straight from TRACK.
        pd_mode = 2;
        drive_pd();
        expect_out("restart_track", 512, 1, 0);
        start_sar();
        check_output();
        expect_out("lo_bit0_pending", 1, 1, 0);
        advance_to(39);
        check_output();
        expect_out("lo_done", 0, 0, 0);
        advance_to(40);
        check_output();
        expect_out("sat_low", 0, 0, 0);
        advance_to(80);
        check_output();

        // Asynchronous reset during bit 5 of SAR, then a full rerun.
        pd_mode = 0;
        target  = 600;
        drive_pd();
        start_sar();
        expect_out("pre_reset", 608, 1, 0);
        advance_to(18);
        check_output();
        #2;
        rst_n = 1'b0;
        expect_out("async_reset", 0, 0, 0);
        #1;
        check_output();
        #1;
        rst_n = 1'b1;
        expect_out("post_reset_idle", 0, 0, 0);
        step_n(4);
        check_output();
        expect_out("rerun_start", 512, 1, 0);
        start_sar();
        check_output();
        expect_out("rerun_bit0_pending", 599, 1, 0);
        advance_to(39);
        check_output();
        expect_out("rerun_done", 599, 0, 0);
        advance_to(40);
        check_output();
        expect_out("rerun_lock", 600, 0, 1);
        advance_to(60);
        check_output();

        // Restart while locked drops lock and reloads the MSB trial.
        expect_out("restart_locked", 512, 1, 0);
        start_sar();
        check_output();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
